// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// state encodings, the NOP control word and ID/EX bus field offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // NOP control word: every write/branch/jump enable deasserted.
  localparam logic [15:0] PIPE_NOP_CTRL = 16'h0000;

  // ID/EX control bus field offsets (bit positions within the 16-bit word).
  localparam int IDEX_CTL_REG_WRITE = 0;
  localparam int IDEX_CTL_MEM_TO_REG = 1;
  localparam int IDEX_CTL_MEM_READ = 2;
  localparam int IDEX_CTL_MEM_WRITE = 3;
  localparam int IDEX_CTL_BRANCH = 4;
  localparam int IDEX_CTL_JUMP = 5;
  localparam int IDEX_CTL_ALU_SRC = 6;
  localparam int IDEX_CTL_REG_DST = 7;
  localparam int IDEX_CTL_ALU_OP_LO = 8;
  localparam int IDEX_CTL_ALU_OP_W = 4;
  localparam int IDEX_CTL_W = 16;

  // ID/EX data bus field offsets (LSB of each field within the 160-bit word).
  localparam int IDEX_DAT_FUNCT = 0;    // 6 bits
  localparam int IDEX_DAT_SHAMT = 6;    // 5 bits
  localparam int IDEX_DAT_RD = 11;      // 5 bits
  localparam int IDEX_DAT_RT = 16;      // 5 bits
  localparam int IDEX_DAT_IMM = 21;     // 32 bits
  localparam int IDEX_DAT_PC = 53;      // 32 bits
  localparam int IDEX_DAT_RT_VAL = 85;  // 32 bits
  localparam int IDEX_DAT_RS_VAL = 117; // 32 bits, bits 149..159 spare
  localparam int IDEX_DAT_W = 160;

  // Number of entries held in a given state.
  function automatic logic [1:0] occupancy_of(pipe_state_t st);
    case (st)
      ST_FULL: occupancy_of = 2'd1;
      ST_SKID: occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One side of a pipeline stage boundary: valid/ready handshake plus
// packed control and data buses.
//
// Handshake: a beat transfers on a posedge where valid & ready are both 1.
// The master holds valid, ctrl and data stable until the beat transfers;
// ready may be asserted independently of valid.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline register: a load-enabled flop bank with
// a synchronous clear back to its reset value.
module pipe_slot #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a squash always leaves the reset value behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer.
// in_ready and out_valid come straight from flops so stalls never create a
// combinational ready path across the stage boundary.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 160,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(PIPE_NOP_CTRL),
  parameter logic [DATA_W-1:0] DATA_RST = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_stage_reg_if.slave         up,
  pipe_stage_reg_if.master        dn,
  output logic [1:0]              occupancy,
  output pipe_state_t             dbg_state
);

  localparam int                SLOT_W   = CTRL_W + DATA_W;
  localparam logic [SLOT_W-1:0] SLOT_RST = {NOP_CTRL, DATA_RST};

  pipe_state_t       state_q, state_n;
  logic              in_ready_q, out_valid_q;
  logic              in_fire, out_fire;
  logic              main_load, main_from_skid, skid_load, slot_clr;
  logic [SLOT_W-1:0] main_d, main_q, skid_q, in_word;

  assign in_word  = {up.ctrl, up.data};
  assign in_fire  = up.valid & in_ready_q;
  assign out_fire = out_valid_q & dn.ready;

  // Next-state and slot-control decode; flush overrides every other move.
  always_comb begin
    state_n        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    slot_clr       = 1'b0;
    if (flush) begin
      state_n  = ST_EMPTY;
      slot_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_n   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_n   = ST_SKID;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_n = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_n        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_n  = ST_EMPTY;
          slot_clr = 1'b1;
        end
      endcase
    end
  end

  // State register with the handshake flags registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      in_ready_q  <= (state_n != ST_SKID);
      out_valid_q <= (state_n != ST_EMPTY);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_word;

  pipe_slot #(.W(SLOT_W), .RST_VAL(SLOT_RST)) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (slot_clr),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_slot #(.W(SLOT_W), .RST_VAL(SLOT_RST)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (slot_clr),
    .load (skid_load),
    .d    (in_word),
    .q    (skid_q)
  );

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid_q;
  // The held control word is never exposed while the output is invalid.
  assign dn.ctrl   = out_valid_q ? main_q[SLOT_W-1:DATA_W] : NOP_CTRL;
  assign dn.data   = main_q[DATA_W-1:0];
  assign occupancy = occupancy_of(state_q);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg at CTRL_W=16, DATA_W=32, NOP=0.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  occupancy;
  pipe_state_t dbg_state;
  int          n_checks;
  int          n_fail;

  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(32)) up_if ();
  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(32)) dn_if ();

  pipe_stage_reg #(
    .CTRL_W   (16),
    .DATA_W   (32),
    .NOP_CTRL (16'h0000),
    .DATA_RST (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .occupancy (occupancy),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] d);
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    dn_if.ready = 1'b0;
    drive(1'b0, 16'h0, 32'h0);
    #2;
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data} !== {4'b0100, 16'h0000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_initial: got v/r/occ=%b ctrl=%h data=%h exp 0100/0000/00000000",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data);
    end
    step();
    rst = 1'b0;
    // build up two entries, then hit reset between clock edges
    drive(1'b1, 16'h5A5A, 32'h12345678);
    step();
    drive(1'b1, 16'h5A5B, 32'h9ABCDEF0);
    step();
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_prefill: got occ=%0d exp 2", occupancy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data, dbg_state} !==
        {4'b0100, 16'h0000, 32'h0, ST_EMPTY}) begin
      n_fail++;
      $display("FAIL reset_midstream: got v/r/occ=%b ctrl=%h data=%h st=%0d exp 0100/0000/00000000/0",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data, dbg_state);
    end
    drive(1'b0, 16'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_nothing_survives: got %b exp 0100", {dn_if.valid, up_if.ready, occupancy});
    end
  endtask

  task automatic test_streaming();
    dn_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0011 + 16'(i), 32'hA0 + 32'(i));
      step();
      n_checks++;
      if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data} !==
          {4'b1101, 16'h0011 + 16'(i), 32'hA0 + 32'(i)}) begin
        n_fail++;
        $display("FAIL stream_%0d: got v/r/occ=%b ctrl=%h data=%h exp 1101/%h/%h", i,
                 {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data,
                 16'h0011 + 16'(i), 32'hA0 + 32'(i));
      end
    end
    drive(1'b0, 16'h0, 32'h0);
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy} !== 4'b0100) begin
      n_fail++;
      $display("FAIL stream_drain: got %b exp 0100", {dn_if.valid, up_if.ready, occupancy});
    end
  endtask

  task automatic test_stall();
    dn_if.ready = 1'b0;
    drive(1'b1, 16'h0021, 32'hB1);
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data} !== {4'b1101, 16'h0021, 32'hB1}) begin
      n_fail++;
      $display("FAIL stall_first: got %b ctrl=%h data=%h exp 1101/0021/000000b1",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data);
    end
    drive(1'b1, 16'h0022, 32'hB2);
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data, dbg_state} !==
        {4'b1010, 16'h0021, 32'hB1, ST_SKID}) begin
      n_fail++;
      $display("FAIL stall_skid: got %b ctrl=%h data=%h st=%0d exp 1010/0021/000000b1/2",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data, dbg_state);
    end
    drive(1'b1, 16'h0023, 32'hB3);
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data} !== {4'b1010, 16'h0021, 32'hB1}) begin
      n_fail++;
      $display("FAIL stall_ignore: got %b ctrl=%h data=%h exp 1010/0021/000000b1",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data);
    end
    drive(1'b0, 16'h0, 32'h0);
    dn_if.ready = 1'b1;
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data} !== {4'b1101, 16'h0022, 32'hB2}) begin
      n_fail++;
      $display("FAIL stall_release_b2: got %b ctrl=%h data=%h exp 1101/0022/000000b2",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data);
    end
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl} !== {4'b0100, 16'h0000}) begin
      n_fail++;
      $display("FAIL stall_drained: got %b ctrl=%h exp 0100/0000",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl);
    end
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    drive(1'b1, 16'h002A, 32'hC1);
    step();
    drive(1'b1, 16'h002B, 32'hC2);
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL flush_prefill: got %b exp 1010", {dn_if.valid, up_if.ready, occupancy});
    end
    drive(1'b1, 16'h0031, 32'hC3);
    flush = 1'b1;
    step();
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data} !== {4'b0100, 16'h0000, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_skid: got %b ctrl=%h data=%h exp 0100/0000/00000000",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data);
    end
    flush = 1'b0;
    drive(1'b0, 16'h0, 32'h0);
    dn_if.ready = 1'b1;
    step();
    n_checks++;
    if ({dn_if.valid, occupancy, dn_if.ctrl} !== {3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL flush_dropped_0031: got v/occ=%b ctrl=%h exp 000/0000",
               {dn_if.valid, occupancy}, dn_if.ctrl);
    end
    // flush from FULL while a new beat and a consume both happen
    drive(1'b1, 16'h0032, 32'hC4);
    step();
    drive(1'b1, 16'h0033, 32'hC5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 32'h0);
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy, dn_if.ctrl, dn_if.data} !== {4'b0100, 16'h0000, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_full: got %b ctrl=%h data=%h exp 0100/0000/00000000",
               {dn_if.valid, up_if.ready, occupancy}, dn_if.ctrl, dn_if.data);
    end
    step();
    n_checks++;
    if ({dn_if.valid, occupancy} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_dropped_0033: got %b exp 000", {dn_if.valid, occupancy});
    end
  endtask

  task automatic test_alternating();
    logic [47:0] exp_q[$];
    logic [47:0] held;
    logic [47:0] e;
    logic        hold;
    int          idx;
    int          rcv;
    int          cyc;
    idx = 0;
    rcv = 0;
    cyc = 0;
    while ((idx < 20 || exp_q.size() != 0) && cyc < 200) begin
      drive(idx < 20, 16'h0100 + 16'(idx), 32'hD000_0000 + 32'(idx));
      dn_if.ready = ~cyc[0];
      hold = dn_if.valid && !dn_if.ready;
      held = {dn_if.ctrl, dn_if.data};
      if (dn_if.valid && dn_if.ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL alt_unexpected: got %h exp nothing outstanding", {dn_if.ctrl, dn_if.data});
        end else begin
          e = exp_q.pop_front();
          if ({dn_if.ctrl, dn_if.data} !== e) begin
            n_fail++;
            $display("FAIL alt_order: got %h exp %h", {dn_if.ctrl, dn_if.data}, e);
          end
        end
        rcv++;
      end
      if (up_if.valid && up_if.ready) begin
        exp_q.push_back({up_if.ctrl, up_if.data});
        idx++;
      end
      step();
      cyc++;
      if (hold) begin
        n_checks++;
        if ({dn_if.ctrl, dn_if.data} !== held) begin
          n_fail++;
          $display("FAIL alt_hold_stable: got %h exp %h", {dn_if.ctrl, dn_if.data}, held);
        end
      end
    end
    drive(1'b0, 16'h0, 32'h0);
    dn_if.ready = 1'b1;
    n_checks++;
    if (rcv != 20 || cyc >= 200) begin
      n_fail++;
      $display("FAIL alt_count: got %0d delivered in %0d cycles exp 20 within 200", rcv, cyc);
    end
    n_checks++;
    if ({dn_if.valid, up_if.ready, occupancy} !== 4'b0100) begin
      n_fail++;
      $display("FAIL alt_final_empty: got %b exp 0100", {dn_if.valid, up_if.ready, occupancy});
    end
  endtask

  task automatic test_masking();
    dn_if.ready = 1'b0;
    drive(1'b1, 16'hFFFF, 32'hCAFEF00D);
    step();
    n_checks++;
    if ({dn_if.valid, dn_if.ctrl, dn_if.data} !== {1'b1, 16'hFFFF, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL mask_loaded: got v=%b ctrl=%h data=%h exp 1/ffff/cafef00d",
               dn_if.valid, dn_if.ctrl, dn_if.data);
    end
    drive(1'b0, 16'h0, 32'h0);
    dn_if.ready = 1'b1;
    step();
    n_checks++;
    if ({dn_if.valid, occupancy, dn_if.ctrl} !== {3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL mask_nop: got v/occ=%b ctrl=%h exp 000/0000", {dn_if.valid, occupancy}, dn_if.ctrl);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_alternating();
    test_masking();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
